// File: rtl/maj_serial_sub.sv
// maj_serial_sub: bit-serial a - b on one majority-gate full-adder cell.
// Define SUB_OVERFLOW_DETECT_EN to add the signed-overflow output ovf.
module maj_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             cout, s;
  logic [WIDTH-1:0] res;

  function automatic logic maj3(
    input logic x, input logic y, input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic maj5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2])
      + 3'(v[3]) + 3'(v[4]);
    return n >= 3'd3;
  endfunction

  // sb already holds ~b, so the cell computes a + ~b + 1
  always_comb begin
    cout = maj3(sa[0], sb[0], carry);
    s    = maj5({sa[0], sb[0], carry, ~cout, ~cout});
    res  = {s, sr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SUB_OVERFLOW_DETECT_EN
      ovf    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        sa    <= a;
        sb    <= ~b;
        carry <= 1'b1;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        sa    <= {1'b0, sa[WIDTH-1:1]};
        sb    <= {1'b0, sb[WIDTH-1:1]};
        sr    <= res[WIDTH-1:1];
        carry <= cout;
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          diff   <= res;
          borrow <= ~cout;
`ifdef SUB_OVERFLOW_DETECT_EN
          ovf    <= carry ^ cout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_maj_serial_sub.sv
// tb_maj_serial_sub: vector table, random ops and corner sequences.
// Checks results against an arithmetic reference model.
module tb_maj_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start4;
  logic [7:0] a, b, diff;
  logic [3:0] a4, b4, diff4;
  logic       busy, done, borrow;
  logic       busy4, done4, borrow4;
`ifdef SUB_OVERFLOW_DETECT_EN
  logic       ovf, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  maj_serial_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .borrow(borrow)
`ifdef SUB_OVERFLOW_DETECT_EN
    , .ovf(ovf)
`endif
  );

  maj_serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .diff(diff4), .borrow(borrow4)
`ifdef SUB_OVERFLOW_DETECT_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bw;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction and sign rules.
  function automatic logic [7:0] m_diff(
    input logic [7:0] x, input logic [7:0] y);
    int r;
    r = int'(x) - int'(y);
    return 8'(r & 255);
  endfunction

  function automatic logic m_ovf(
    input logic [7:0] x, input logic [7:0] y);
    int sx, sy, r;
    sx = x[7] ? int'(x) - 256 : int'(x);
    sy = y[7] ? int'(y) - 256 : int'(y);
    r  = sx - sy;
    return (r > 127) || (r < -128);
  endfunction

  logic [7:0] r_d;
  logic       r_bw, r_ov, r_after;
  int         r_lat, r_busy;

  task automatic do_op(input logic [7:0] x,
                       input logic [7:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_lat = 1; r_busy = 0;
    while (!done && r_lat < 30) begin
      if (busy) r_busy++;
      r_lat++;
      @(negedge clk);
    end
    if (!done) chk("timeout8", 0, 1);
    r_d = diff; r_bw = borrow;
`ifdef SUB_OVERFLOW_DETECT_EN
    r_ov = ovf;
`else
    r_ov = 1'b0;
`endif
    @(negedge clk);
    r_after = done;
  endtask

  task automatic check_op(input string nm,
                          input logic [7:0] x,
                          input logic [7:0] y,
                          input logic [7:0] d,
                          input logic bw,
                          input logic ov);
    do_op(x, y);
    chk({nm, "_diff"}, 32'(r_d), 32'(d));
    chk({nm, "_borrow"}, 32'(r_bw), 32'(bw));
`ifdef SUB_OVERFLOW_DETECT_EN
    chk({nm, "_ovf"}, 32'(r_ov), 32'(ov));
`else
    if (ov === 1'bx) chk({nm, "_ovf"}, 0, 1);
`endif
  endtask

  task automatic op4(input logic [3:0] x,
                     input logic [3:0] y);
    int n;
    logic [3:0] ed;
    @(negedge clk);
    a4 = x; b4 = y; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!done4) chk("timeout4", 0, 1);
    ed = 4'((int'(x) - int'(y)) & 15);
    chk("w4_diff", 32'(diff4), 32'(ed));
    chk("w4_borrow", 32'(borrow4), 32'(x < y));
  endtask

  initial begin
    int i;
    logic [7:0] x, y;

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow), 0);
`ifdef SUB_OVERFLOW_DETECT_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      check_op($sformatf("tbl%0d", k), tbl[k].a,
               tbl[k].b, tbl[k].d, tbl[k].bw,
               tbl[k].ov);
      chk("lat_done", 32'(r_lat), 9);
      chk("lat_busy", 32'(r_busy), 8);
      chk("done_pulse", 32'(r_after), 0);
    end

    for (int k = 0; k < 40; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      check_op("rand", x, y, m_diff(x, y),
               x < y, m_ovf(x, y));
    end

    // start held high and operands churning while busy
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    i = 0;
    while (i < 15) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      if (done) break;
      i++;
    end
    chk("hold_cycle", 32'(i), 8);
    chk("hold_diff", 32'(diff), 32'h0F);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_idle_done", 32'(done), 0);
    start = 1'b0;
    check_op("after_hold", 8'h44, 8'h11, 8'h33,
             1'b0, 1'b0);

    // reset in the 4th SHIFT cycle
    @(negedge clk);
    a = 8'h20; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_diff", 32'(diff), 0);
    chk("mid_borrow", 32'(borrow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_idle", 32'(busy), 0);
    check_op("post_rst", 8'h09, 8'h04, 8'h05,
             1'b0, 1'b0);

    for (int p = 0; p < 16; p++)
      for (int q = 0; q < 16; q++)
        op4(4'(p), 4'(q));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
